// File: rtl/toy_lsu_buffer_mp_pkg.sv
// toy_lsu_buffer_mp_pkg: shared uop/forwarding types and widths for the LSU issue buffer
package toy_lsu_buffer_mp_pkg;
  localparam int EU_NUM = 4;
  localparam int REG_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int LSU_ID_W = 8;
  localparam int STU_DEPTH_DEF = 16;
  localparam int EU_ID_W = $clog2(EU_NUM);
  typedef struct packed {
    logic [1:0]         rs1_forward_cycle;
    logic [EU_ID_W-1:0] rs1_forward_id;
    logic [1:0]         rs2_forward_cycle;
    logic [EU_ID_W-1:0] rs2_forward_id;
  } fwd_pld_t;
  typedef struct packed {
    logic [LSU_ID_W-1:0]   lsu_id;
    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] imm;
    logic [REG_WIDTH-1:0]  reg_rs1_val;
    logic [REG_WIDTH-1:0]  reg_rs2_val;
    fwd_pld_t              fwd_pld;
  } eu_pkg;
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/toy_lsu_buffer_lane_sel.sv
// toy_lsu_buffer_lane_sel: head-relative lane slot index, prefix valid/credit gating, in-order fire chain and drain counts
module toy_lsu_buffer_lane_sel import toy_lsu_buffer_mp_pkg::*; #(
  parameter int M_CHANNEL = 2,
  parameter int DEPTH = 16,
  parameter int STU_DEPTH = STU_DEPTH_DEF
) (
  input  logic [$clog2(DEPTH)-1:0]                head_i,
  input  logic [DEPTH-1:0]                        slot_vld_i,
  input  logic [DEPTH-1:0]                        slot_stu_i,
  input  logic [M_CHANNEL-1:0]                    rdy_i,
  input  logic [$clog2(STU_DEPTH):0]              credit_i,
  output logic [M_CHANNEL-1:0][$clog2(DEPTH)-1:0] idx_o,
  output logic [M_CHANNEL-1:0]                    vld_o,
  output logic [M_CHANNEL-1:0]                    stu_o,
  output logic [M_CHANNEL-1:0]                    fire_o,
  output logic [$clog2(M_CHANNEL):0]              deq_cnt_o,
  output logic [$clog2(M_CHANNEL):0]              fire_stu_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int DW = $clog2(M_CHANNEL) + 1;
  logic [31:0] st;
  logic        cv;
  logic        cf;
  always_comb begin
    st = '0;
    cv = 1'b1;
    cf = 1'b1;
    idx_o = '0;
    vld_o = '0;
    stu_o = '0;
    fire_o = '0;
    deq_cnt_o = '0;
    fire_stu_o = '0;
    for (int k = 0; k < M_CHANNEL; k++) begin
      idx_o[k] = head_i + IW'(k);
      stu_o[k] = slot_stu_i[idx_o[k]];
      st = st + 32'(stu_o[k]);
      cv = cv & slot_vld_i[idx_o[k]] & (st <= 32'(credit_i));
      cf = cf & cv & rdy_i[k];
      vld_o[k] = cv;
      fire_o[k] = cf;
      deq_cnt_o = deq_cnt_o + DW'(cf);
      fire_stu_o = fire_stu_o + DW'(cf & stu_o[k]);
    end
  end
endmodule

// File: rtl/toy_lsu_buffer_mp.sv
// toy_lsu_buffer_mp: in-order multi-port LSU issue buffer (id-indexed writes, M-lane drain, forwarding capture, store credits, cancel flush; LSU_BUF_PERF_CNT_EN adds perf_credit_stall/perf_head_empty)
module toy_lsu_buffer_mp import toy_lsu_buffer_mp_pkg::*; #(
  parameter int S_CHANNEL = 4,
  parameter int M_CHANNEL = 2,
  parameter int DEPTH = 16,
  parameter int STU_DEPTH = STU_DEPTH_DEF,
  parameter int CRD_W = 4
) (
  input  logic                               clk,
  input  logic                               rst,
`ifdef LSU_BUF_PERF_CNT_EN
  output logic [31:0]                        perf_credit_stall,
  output logic [31:0]                        perf_head_empty,
`endif
  input  logic [S_CHANNEL-1:0]               s_vld,
  input  eu_pkg [S_CHANNEL-1:0]              s_pld,
  input  logic [S_CHANNEL-1:0]               s_stu_en,
  input  logic [EU_NUM-1:0][REG_WIDTH-1:0]   v_forward_data,
  output logic [M_CHANNEL-1:0]               m_vld,
  input  logic [M_CHANNEL-1:0]               m_rdy,
  output eu_pkg [M_CHANNEL-1:0]              m_pld,
  output logic [M_CHANNEL-1:0]               m_stu_en,
  output logic [$clog2(DEPTH):0]             rd_ptr,
  output logic [$clog2(M_CHANNEL):0]         deq_cnt,
  input  logic                               cancel_en,
  input  logic                               stu_credit_en,
  input  logic [CRD_W-1:0]                   stu_credit_num,
  input  logic [$clog2(STU_DEPTH)-1:0]       stq_commit_cnt,
  output logic [$clog2(STU_DEPTH):0]         stu_credit_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STU_DEPTH) + 1;
  localparam int DW = $clog2(M_CHANNEL) + 1;
  localparam int SW = S_CHANNEL > 1 ? $clog2(S_CHANNEL) : 1;
  localparam int SUMW = CW + CRD_W + 1;
  eu_pkg [DEPTH-1:0]                mem_q;
  logic [DEPTH-1:0]                 vld_q, vld_d, stu_q, stu_d, p1_q, p1_d, p2_q, p2_d;
  logic [DEPTH-1:0]                 wr_en, clr;
  logic [SW-1:0]                    wr_sel [DEPTH];
  logic                             multi_wr;
  logic [DEPTH-1:0][REG_WIDTH-1:0]  fwd1, fwd2;
  logic [PW-1:0]                    rd_ptr_q;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [SUMW-1:0]                  sum;
  logic [M_CHANNEL-1:0][AW-1:0]     idx;
  logic [M_CHANNEL-1:0]             fire;
  logic [DW-1:0]                    fire_stu;
  toy_lsu_buffer_lane_sel #(
    .M_CHANNEL(M_CHANNEL),
    .DEPTH(DEPTH),
    .STU_DEPTH(STU_DEPTH)
  ) u_lane_sel (
    .head_i(rd_ptr_q[AW-1:0]),
    .slot_vld_i(vld_q),
    .slot_stu_i(stu_q),
    .rdy_i(m_rdy),
    .credit_i(cnt_q),
    .idx_o(idx),
    .vld_o(m_vld),
    .stu_o(m_stu_en),
    .fire_o(fire),
    .deq_cnt_o(deq_cnt),
    .fire_stu_o(fire_stu)
  );
  // ascending channel scan so the highest channel targeting a slot wins
  always_comb begin
    wr_en = '0;
    multi_wr = 1'b0;
    for (int j = 0; j < DEPTH; j++) wr_sel[j] = '0;
    for (int i = 0; i < S_CHANNEL; i++)
      for (int j = 0; j < DEPTH; j++)
        if (s_vld[i] && s_pld[i].lsu_id[AW-1:0] == AW'(j)) begin
          multi_wr = multi_wr | wr_en[j];
          wr_en[j] = 1'b1;
          wr_sel[j] = SW'(i);
        end
  end
  always_comb begin
    clr = '0;
    for (int k = 0; k < M_CHANNEL; k++) if (fire[k]) clr[idx[k]] = 1'b1;
  end
  // a write re-arms the slot even if it is being drained this same cycle
  always_comb begin
    vld_d = (vld_q & ~clr) | wr_en;
    stu_d = stu_q;
    p1_d = '0;
    p2_d = '0;
    for (int j = 0; j < DEPTH; j++) begin
      fwd1[j] = v_forward_data[mem_q[j].fwd_pld.rs1_forward_id];
      fwd2[j] = v_forward_data[mem_q[j].fwd_pld.rs2_forward_id];
      if (wr_en[j]) begin
        stu_d[j] = s_stu_en[wr_sel[j]];
        p1_d[j] = s_pld[wr_sel[j]].fwd_pld.rs1_forward_cycle[1];
        p2_d[j] = s_pld[wr_sel[j]].fwd_pld.rs2_forward_cycle[1];
      end
    end
  end
  // a slot read during its forwarding cycle sees the bus value directly
  always_comb begin
    for (int k = 0; k < M_CHANNEL; k++) begin
      m_pld[k] = mem_q[idx[k]];
      m_pld[k].reg_rs1_val = p1_q[idx[k]] ? fwd1[idx[k]] : mem_q[idx[k]].reg_rs1_val;
      m_pld[k].reg_rs2_val = p2_q[idx[k]] ? fwd2[idx[k]] : mem_q[idx[k]].reg_rs2_val;
    end
  end
  always_comb begin
    sum = SUMW'(cnt_q) + (stu_credit_en ? SUMW'(stu_credit_num) : SUMW'(0)) - SUMW'(fire_stu);
    cnt_d = cancel_en ? CW'(STU_DEPTH) - CW'(stq_commit_cnt) :
            sum > SUMW'(STU_DEPTH) ? CW'(STU_DEPTH) : CW'(sum);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      stu_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= CW'(STU_DEPTH);
    end else begin
      cnt_q <= cnt_d;
      if (cancel_en) begin
        vld_q <= '0;
        p1_q <= '0;
        p2_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        vld_q <= vld_d;
        stu_q <= stu_d;
        p1_q <= p1_d;
        p2_q <= p2_d;
        rd_ptr_q <= rd_ptr_q + PW'(deq_cnt);
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (wr_en[j] && !cancel_en) mem_q[j] <= s_pld[wr_sel[j]];
      else begin
        if (p1_q[j]) mem_q[j].reg_rs1_val <= fwd1[j];
        if (p2_q[j]) mem_q[j].reg_rs2_val <= fwd2[j];
      end
    end
  end
  assign rd_ptr = rd_ptr_q;
  assign stu_credit_cnt = cnt_q;
`ifdef LSU_BUF_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_empty_q;
  logic        head_v;
  assign head_v = vld_q[rd_ptr_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_empty_q <= '0;
    end else begin
      if (head_v && !m_vld[0]) perf_stall_q <= sat_inc32(perf_stall_q);
      if (!head_v) perf_empty_q <= sat_inc32(perf_empty_q);
    end
  end
  assign perf_credit_stall = perf_stall_q;
  assign perf_head_empty = perf_empty_q;
`endif
  a_single_writer: assert property (@(posedge clk) disable iff (rst) !multi_wr);
  a_credit_ovf: assert property (@(posedge clk) disable iff (rst) cancel_en || sum <= SUMW'(STU_DEPTH));
endmodule

// File: tb/tb_toy_lsu_buffer_mp.sv
// tb_toy_lsu_buffer_mp: table-driven drain/wrap/cancel vectors plus hand sequences for credit gating, forwarding and reset
module tb_toy_lsu_buffer_mp;
  import toy_lsu_buffer_mp_pkg::*;
  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic [3:0]                       s_vld, s_stu_en;
  eu_pkg [3:0]                      s_pld;
  logic [EU_NUM-1:0][REG_WIDTH-1:0] v_forward_data;
  logic [1:0]                       m_vld, m_rdy, m_stu_en;
  eu_pkg [1:0]                      m_pld;
  logic [4:0]                       rd_ptr;
  logic [1:0]                       deq_cnt;
  logic                             cancel_en, stu_credit_en;
  logic [3:0]                       stu_credit_num, stq_commit_cnt;
  logic [4:0]                       stu_credit_cnt;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [3:0]  s_vld;
    logic [31:0] ids;
    logic [1:0]  rdy;
    logic        cancel;
    logic [3:0]  commit;
    logic [1:0]  e_mvld;
    logic [1:0]  e_deq;
    logic [4:0]  e_ptr;
    logic [4:0]  e_cnt;
    logic [7:0]  e_id0;
    logic [7:0]  e_id1;
  } vec_t;
  vec_t tv [18];
  toy_lsu_buffer_mp dut (
    .clk(clk),
    .rst(rst),
    .s_vld(s_vld),
    .s_pld(s_pld),
    .s_stu_en(s_stu_en),
    .v_forward_data(v_forward_data),
    .m_vld(m_vld),
    .m_rdy(m_rdy),
    .m_pld(m_pld),
    .m_stu_en(m_stu_en),
    .rd_ptr(rd_ptr),
    .deq_cnt(deq_cnt),
    .cancel_en(cancel_en),
    .stu_credit_en(stu_credit_en),
    .stu_credit_num(stu_credit_num),
    .stq_commit_cnt(stq_commit_cnt),
    .stu_credit_cnt(stu_credit_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    s_vld = '0;
    s_stu_en = '0;
    s_pld = '0;
    m_rdy = '0;
    cancel_en = 1'b0;
    stu_credit_en = 1'b0;
    stu_credit_num = '0;
    stq_commit_cnt = '0;
  endtask
  function automatic eu_pkg mk(input logic [7:0] id, input logic [31:0] r1, input logic [31:0] r2, input logic f1, input logic [1:0] fid);
    eu_pkg p;
    p = '0;
    p.lsu_id = id;
    p.reg_rs1_val = r1;
    p.reg_rs2_val = r2;
    p.fwd_pld.rs1_forward_cycle = {f1, 1'b0};
    p.fwd_pld.rs1_forward_id = fid;
    return p;
  endfunction
  initial begin
    idle();
    v_forward_data = '0;
    tv[0]  = '{4'b1111, 32'h03020100, 2'b11, 1'b0, 4'd0, 2'b00, 2'd0, 5'd0,  5'd16, 8'd0,  8'd0};
    tv[1]  = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd0,  5'd16, 8'd0,  8'd1};
    tv[2]  = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd2,  5'd16, 8'd2,  8'd3};
    tv[3]  = '{4'b0011, 32'h00000504, 2'b00, 1'b0, 4'd0, 2'b00, 2'd0, 5'd4,  5'd16, 8'd0,  8'd0};
    tv[4]  = '{4'b0000, 32'h0,        2'b10, 1'b0, 4'd0, 2'b11, 2'd0, 5'd4,  5'd16, 8'd4,  8'd5};
    tv[5]  = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd4,  5'd16, 8'd4,  8'd5};
    tv[6]  = '{4'b1111, 32'h09080706, 2'b00, 1'b0, 4'd0, 2'b00, 2'd0, 5'd6,  5'd16, 8'd0,  8'd0};
    tv[7]  = '{4'b1111, 32'h0d0c0b0a, 2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd6,  5'd16, 8'd6,  8'd7};
    tv[8]  = '{4'b0001, 32'h0000000e, 2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd8,  5'd16, 8'd8,  8'd9};
    tv[9]  = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd10, 5'd16, 8'd10, 8'd11};
    tv[10] = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd12, 5'd16, 8'd12, 8'd13};
    tv[11] = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b01, 2'd1, 5'd14, 5'd16, 8'd14, 8'd0};
    tv[12] = '{4'b0011, 32'h0000000f, 2'b11, 1'b0, 4'd0, 2'b00, 2'd0, 5'd15, 5'd16, 8'd0,  8'd0};
    tv[13] = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b11, 2'd2, 5'd15, 5'd16, 8'd15, 8'd0};
    tv[14] = '{4'b1111, 32'h04030201, 2'b00, 1'b0, 4'd0, 2'b00, 2'd0, 5'd17, 5'd16, 8'd0,  8'd0};
    tv[15] = '{4'b0011, 32'h00000605, 2'b00, 1'b0, 4'd0, 2'b11, 2'd0, 5'd17, 5'd16, 8'd1,  8'd2};
    tv[16] = '{4'b0001, 32'h00000000, 2'b01, 1'b1, 4'd3, 2'b11, 2'd1, 5'd17, 5'd16, 8'd1,  8'd2};
    tv[17] = '{4'b0000, 32'h0,        2'b11, 1'b0, 4'd0, 2'b00, 2'd0, 5'd0,  5'd13, 8'd0,  8'd0};
    step();
    chk("rst_mvld", m_vld, 2'b00);
    chk("rst_deq", deq_cnt, 2'd0);
    chk("rst_ptr", rd_ptr, 5'd0);
    chk("rst_cnt", stu_credit_cnt, 5'd16);
    step();
    rst = 1'b0;
    for (int n = 0; n < 18; n++) begin
      idle();
      s_vld = tv[n].s_vld;
      for (int i = 0; i < 4; i++) s_pld[i] = mk(tv[n].ids[8*i+:8], 32'h0, 32'h0, 1'b0, 2'd0);
      m_rdy = tv[n].rdy;
      cancel_en = tv[n].cancel;
      stq_commit_cnt = tv[n].commit;
      #1;
      chk($sformatf("v%0d_mvld", n), m_vld, tv[n].e_mvld);
      chk($sformatf("v%0d_deq", n), deq_cnt, tv[n].e_deq);
      chk($sformatf("v%0d_ptr", n), rd_ptr, tv[n].e_ptr);
      chk($sformatf("v%0d_cnt", n), stu_credit_cnt, tv[n].e_cnt);
      if (tv[n].e_mvld[0]) chk($sformatf("v%0d_id0", n), m_pld[0].lsu_id, tv[n].e_id0);
      if (tv[n].e_mvld[1]) chk($sformatf("v%0d_id1", n), m_pld[1].lsu_id, tv[n].e_id1);
      step();
    end
    idle();
    cancel_en = 1'b1;
    stq_commit_cnt = 4'd15;
    step();
    idle();
    chk("crd_after_cancel", stu_credit_cnt, 5'd1);
    s_vld = 4'b0011;
    s_stu_en = 4'b0011;
    s_pld[0] = mk(8'd0, 32'h0, 32'h0, 1'b0, 2'd0);
    s_pld[1] = mk(8'd1, 32'h0, 32'h0, 1'b0, 2'd0);
    step();
    idle();
    m_rdy = 2'b01;
    #1;
    chk("crd_gate_mvld", m_vld, 2'b01);
    chk("crd_gate_stu", m_stu_en, 2'b11);
    chk("crd_gate_deq", deq_cnt, 2'd1);
    step();
    idle();
    stu_credit_en = 1'b1;
    stu_credit_num = 4'd3;
    #1;
    chk("crd_zero_cnt", stu_credit_cnt, 5'd0);
    chk("crd_zero_mvld", m_vld, 2'b00);
    chk("crd_zero_deq", deq_cnt, 2'd0);
    step();
    idle();
    m_rdy = 2'b01;
    #1;
    chk("crd_ret_cnt", stu_credit_cnt, 5'd3);
    chk("crd_ret_mvld", m_vld, 2'b01);
    chk("crd_ret_deq", deq_cnt, 2'd1);
    step();
    idle();
    #1;
    chk("crd_end_cnt", stu_credit_cnt, 5'd2);
    chk("crd_end_ptr", rd_ptr, 5'd2);
    chk("crd_end_mvld", m_vld, 2'b00);
    s_vld = 4'b0111;
    for (int i = 0; i < 3; i++) s_pld[i] = mk(8'(i + 2), 32'h0, 32'h0, 1'b0, 2'd0);
    m_rdy = 2'b11;
    step();
    idle();
    s_vld = 4'b0001;
    s_pld[0] = mk(8'd5, 32'h1111, 32'h2222, 1'b1, 2'd2);
    m_rdy = 2'b11;
    #1;
    chk("fwd_pre_deq", deq_cnt, 2'd2);
    step();
    idle();
    v_forward_data[2] = 32'hDEAD_BEEF;
    m_rdy = 2'b01;
    #1;
    chk("fwd_same_mvld", m_vld, 2'b11);
    chk("fwd_same_id", m_pld[1].lsu_id, 8'd5);
    chk("fwd_same_rs1", m_pld[1].reg_rs1_val, 32'hDEAD_BEEF);
    chk("fwd_same_rs2", m_pld[1].reg_rs2_val, 32'h2222);
    chk("fwd_same_deq", deq_cnt, 2'd1);
    step();
    idle();
    v_forward_data = '0;
    m_rdy = 2'b01;
    #1;
    chk("fwd_late_id", m_pld[0].lsu_id, 8'd5);
    chk("fwd_late_rs1", m_pld[0].reg_rs1_val, 32'hDEAD_BEEF);
    chk("fwd_late_rs2", m_pld[0].reg_rs2_val, 32'h2222);
    chk("fwd_late_deq", deq_cnt, 2'd1);
    step();
    idle();
    s_vld = 4'b0001;
    s_pld[0] = mk(8'd6, 32'h0, 32'h0, 1'b0, 2'd0);
    step();
    idle();
    #1;
    chk("mid_mvld", m_vld, 2'b01);
    chk("mid_cnt", stu_credit_cnt, 5'd2);
    chk("mid_ptr", rd_ptr, 5'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst2_cnt", stu_credit_cnt, 5'd16);
    chk("rst2_ptr", rd_ptr, 5'd0);
    chk("rst2_mvld", m_vld, 2'b00);
    chk("rst2_deq", deq_cnt, 2'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/toy_lsu_buffer_mp.md
Name: toy_lsu_buffer_mp

Overview:
Multi-port in-order LSU issue buffer. Dispatch writes up to S_CHANNEL uops per cycle into slots indexed by lsu_id. Up to M_CHANNEL oldest uops drain per cycle to the LSU pipes, in order. Sits between the EU issue stage and the load/store pipes, and adds operand forwarding capture, store-queue credit gating and flush on cancel.

Parameters:
S_CHANNEL, 4, write (dispatch) channels; any value >=1, channel OR/priority generated generically
M_CHANNEL, 2, read lanes per cycle; 1..DEPTH
DEPTH, 16, slots; power of two
STU_DEPTH, 16, store-queue entries (initial credit)
CRD_W, 4, width of credit-return count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_vld  in  S_CHANNEL  per-channel write valid
s_pld  in  eu_pkg[S_CHANNEL]  uop; lsu_id[log2(DEPTH)-1:0] selects slot
s_stu_en  in  S_CHANNEL  uop is a store
v_forward_data  in  REG_WIDTH[EU_NUM]  EU result bus for late operands
m_vld  out  M_CHANNEL  lane valid
m_rdy  in  M_CHANNEL  lane ready
m_pld  out  eu_pkg[M_CHANNEL]  lane uop, forwarded operands merged
m_stu_en  out  M_CHANNEL  lane uop is a store
rd_ptr  out  log2(DEPTH)+1  head pointer with wrap bit
deq_cnt  out  log2(M_CHANNEL)+1  uops drained this cycle
cancel_en  in  1  flush
stu_credit_en  in  1  credit return valid
stu_credit_num  in  CRD_W  credits returned
stq_commit_cnt  in  log2(STU_DEPTH)  committed stores still held at cancel
stu_credit_cnt  out  log2(STU_DEPTH)+1  current store credits

Behaviour:
- Reset (rst high at clk edge): all slot-valid, forward-pending and stu_en bits 0; rd_ptr=0; stu_credit_cnt=STU_DEPTH; m_vld=0; deq_cnt=0. Payload is not reset.
- Write: slot j is written when any s_vld[i] has lsu_id==j. If several channels target one slot, the highest i wins. That case is illegal and flagged by assertion. Write sets valid, latches the payload and stu_en, and sets fwd-pending rs1/rs2 from fwd_pld.rsX_forward_cycle[1].
- Forward: a pending bit lives exactly one cycle. In that cycle, mem.reg_rsX_val <= v_forward_data[rsX_forward_id] and the bit clears. If a pending slot is read that same cycle, m_pld uses the bus value combinationally.
- Lane k reads slot (rd_ptr+k) mod DEPTH.
  - m_vld[k] = slot valid & m_vld[k-1] (k>0) & credit_ok[k].
  - credit_ok[k] = (stores among lanes 0..k) <= stu_credit_cnt.
  - m_vld does not depend on m_rdy.
- Fire: fire[0]=m_vld[0]&m_rdy[0]; fire[k]=fire[k-1]&m_vld[k]&m_rdy[k]. A ready lane above a non-fired lane does not fire. deq_cnt = popcount(fire).
- Fired slots clear their valid bit; rd_ptr += deq_cnt, wrapping naturally over log2(DEPTH)+1 bits. A write to a slot beats the clear of that slot in the same cycle.
- Credit (next value): cancel -> STU_DEPTH - stq_commit_cnt; else cnt + (stu_credit_en ? stu_credit_num : 0) - fired stores. Saturates at STU_DEPTH; assertion on overflow.
- Cancel: next cycle, all valid and pending bits are 0 and rd_ptr=0. Writes and fires in the cancel cycle are discarded. deq_cnt still reports fires that cycle.
- Reset has priority over cancel. Cancel has priority over write.
- Full/empty are tracked by dispatch via lsu_id. This block does not backpressure writes.

Optional Feature:
LSU_BUF_PERF_CNT_EN: adds outputs perf_credit_stall (32b) and perf_head_empty (32b).
- perf_credit_stall increments on cycles where the head slot is valid but m_vld[0]=0.
- perf_head_empty increments on cycles where the head slot is invalid.
- Both are cleared by rst and not by cancel; each saturates at all-ones.
Without the macro, the ports and counters are absent.

Decomposition:
- toy_pack: eu_pkg, fwd_pld fields, EU_NUM, REG_WIDTH, ADDR_WIDTH, STU_DEPTH default.
- One sub-module, toy_lsu_buffer_lane_sel: head-relative slot index, prefix valid/credit and fire chain, deq_cnt popcount.
- Slot storage and forwarding capture stay in the top.

Test Plan:
- In-order dual drain: write ids 0..3 (loads) on one cycle, all m_rdy=1 -> cycle+1 lanes fire ids 0,1; cycle+2 fire ids 2,3; rd_ptr 0->2->4.
- Ready hole: head holds ids 0,1, m_rdy=2'b10 -> deq_cnt=0, rd_ptr unchanged; next cycle m_rdy=2'b11 -> both fire.
- Credit gate: stu_credit_cnt=1, head two stores -> m_vld=2'b01. Fire it -> cnt=0, m_vld=0. stu_credit_en=1 with num=3 -> cnt=3, store drains.
- Forward: write id 5 with rs1_forward_cycle[1]=1 and rs1_forward_id=2; next cycle drive v_forward_data[2]=32'hDEAD_BEEF -> slot 5 reads back rs1 with that value, both when read the same cycle and later.
- Wrap: DEPTH=16, rd_ptr=15, slots 15 and 0 valid -> both fire, rd_ptr=17, i.e. 5'b10001.
- Cancel mid-drain: 6 valid, cancel_en=1 with stq_commit_cnt=3 -> next cycle m_vld=0, rd_ptr=0, stu_credit_cnt=13. Rst mid-run -> credit 16.
